// File: rtl/memory_stage.sv
// Data-memory stage: RAM plus LED/HEX/switch I/O, registered to writeback on the falling edge.
// Latency one negedge; no backpressure, bubbles (lock low or stall flags) suppress all side effects.
module memory_stage #(
   parameter int                 DATA_WIDTH   = 16,
   parameter int                 OPCODE_WIDTH = 8,
   parameter int                 ADDR_BITS    = 10,
   parameter logic [15:0]        LEDR_ADDR    = 16'hFF00,
   parameter logic [15:0]        HEX_ADDR     = 16'hFF01,
   parameter logic [15:0]        SW_ADDR      = 16'hFF02
) (
   input  logic                    I_CLOCK,
   input  logic                    I_RESET,
   input  logic                    I_LOCK,
   input  logic [DATA_WIDTH-1:0]   I_ALUOut,
   input  logic [DATA_WIDTH-1:0]   I_StoreData,
   input  logic [OPCODE_WIDTH-1:0] I_Opcode,
   input  logic [3:0]              I_DestRegIdx,
   input  logic                    I_FetchStall,
   input  logic                    I_DepStall,
   input  logic [9:0]              I_Switches,
   output logic                    O_LOCK,
   output logic [DATA_WIDTH-1:0]   O_ALUOut,
   output logic [DATA_WIDTH-1:0]   O_MemOut,
   output logic [OPCODE_WIDTH-1:0] O_Opcode,
   output logic [3:0]              O_DestRegIdx,
   output logic                    O_RegWrite,
   output logic                    O_FetchStall,
   output logic                    O_DepStall,
   output logic [9:0]              O_LEDR,
   output logic [15:0]             O_HEX
);

   // Opcode map shared with the rest of the pipeline; upper nibble 3 is the branch class.
   localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 8'h00;
   localparam logic [OPCODE_WIDTH-1:0] OP_LDW = 8'h20;
   localparam logic [OPCODE_WIDTH-1:0] OP_STW = 8'h21;
   localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 8'h40;
   localparam logic [OPCODE_WIDTH-1:0] OP_RET = 8'h41;
   localparam logic [3:0]              BR_CLASS = 4'h3;

   logic [DATA_WIDTH-1:0] ram [0:(2**ADDR_BITS)-1];

   logic [9:0]            sw_meta;
   logic [9:0]            sw_sync;
   logic                  valid;
   logic                  is_ldw;
   logic                  is_stw;
   logic                  no_wb;
   logic                  hit_ledr;
   logic                  hit_hex;
   logic                  hit_sw;
   logic                  ram_we;
   logic                  reg_write_nxt;
   logic [ADDR_BITS-1:0]  ram_addr;
   logic [DATA_WIDTH-1:0] load_dat;

   always_comb begin
      valid         = I_LOCK & ~I_FetchStall & ~I_DepStall;
      is_ldw        = (I_Opcode == OP_LDW);
      is_stw        = (I_Opcode == OP_STW);
      hit_ledr      = (I_ALUOut == LEDR_ADDR);
      hit_hex       = (I_ALUOut == HEX_ADDR);
      hit_sw        = (I_ALUOut == SW_ADDR);
      ram_addr      = I_ALUOut[ADDR_BITS-1:0];
      ram_we        = valid & is_stw & ~hit_ledr & ~hit_hex & ~hit_sw;
      no_wb         = is_stw || (I_Opcode == OP_NOP) || (I_Opcode == OP_JMP) ||
                      (I_Opcode == OP_RET) || (I_Opcode[7:4] == BR_CLASS);
      reg_write_nxt = valid & ~no_wb;

      load_dat = ram[ram_addr];
      if (hit_ledr)
         load_dat = {{(DATA_WIDTH-10){1'b0}}, O_LEDR};
      else if (hit_hex)
         load_dat = O_HEX;
      else if (hit_sw)
         load_dat = {{(DATA_WIDTH-10){1'b0}}, sw_sync};
   end

   // RAM is never cleared; reset only blocks a store landing on the edge it asserts.
   always_ff @(negedge I_CLOCK) begin
      if (ram_we && !I_RESET)
         ram[ram_addr] <= I_StoreData;
   end

   always_ff @(negedge I_CLOCK or posedge I_RESET) begin
      if (I_RESET) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= I_Switches;
         sw_sync <= sw_meta;
      end
   end

   always_ff @(negedge I_CLOCK or posedge I_RESET) begin
      if (I_RESET) begin
         O_LOCK       <= 1'b0;
         O_ALUOut     <= '0;
         O_MemOut     <= '0;
         O_Opcode     <= '0;
         O_DestRegIdx <= '0;
         O_RegWrite   <= 1'b0;
         O_FetchStall <= 1'b0;
         O_DepStall   <= 1'b0;
         O_LEDR       <= '0;
         O_HEX        <= '0;
      end else begin
         O_LOCK       <= I_LOCK;
         O_FetchStall <= I_FetchStall;
         O_DepStall   <= I_DepStall;
         O_Opcode     <= I_Opcode;
         O_DestRegIdx <= I_DestRegIdx;
         O_ALUOut     <= I_ALUOut;
         O_RegWrite   <= reg_write_nxt;
         if (valid && is_ldw)
            O_MemOut <= load_dat;
         if (valid && is_stw && hit_ledr)
            O_LEDR <= I_StoreData[9:0];
         if (valid && is_stw && hit_hex)
            O_HEX <= I_StoreData[15:0];
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: inputs driven on posedge, outputs sampled on posedge (DUT acts on negedge).
module tb_memory_stage;

   localparam logic [7:0] OP_NOP = 8'h00;
   localparam logic [7:0] OP_ADD = 8'h01;
   localparam logic [7:0] OP_LDW = 8'h20;
   localparam logic [7:0] OP_STW = 8'h21;
   localparam logic [7:0] OP_BEQ = 8'h30;
   localparam logic [7:0] OP_JMP = 8'h40;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_lock = 1'b0;
   logic [15:0] i_alu = '0;
   logic [15:0] i_sd = '0;
   logic [7:0]  i_op = '0;
   logic [3:0]  i_dest = '0;
   logic        i_fs = 1'b0;
   logic        i_ds = 1'b0;
   logic [9:0]  i_sw = '0;
   logic        o_lock;
   logic [15:0] o_alu;
   logic [15:0] o_mem;
   logic [7:0]  o_op;
   logic [3:0]  o_dest;
   logic        o_rw;
   logic        o_fs;
   logic        o_ds;
   logic [9:0]  o_ledr;
   logic [15:0] o_hex;

   int checks = 0;
   int failures = 0;

   memory_stage dut (
      .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(i_lock), .I_ALUOut(i_alu),
      .I_StoreData(i_sd), .I_Opcode(i_op), .I_DestRegIdx(i_dest),
      .I_FetchStall(i_fs), .I_DepStall(i_ds), .I_Switches(i_sw),
      .O_LOCK(o_lock), .O_ALUOut(o_alu), .O_MemOut(o_mem), .O_Opcode(o_op),
      .O_DestRegIdx(o_dest), .O_RegWrite(o_rw), .O_FetchStall(o_fs),
      .O_DepStall(o_ds), .O_LEDR(o_ledr), .O_HEX(o_hex)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one instruction at a posedge; return at the next posedge, after the negedge that registers it.
   task automatic issue(input logic [7:0] op, input logic [15:0] a, input logic [15:0] d,
                        input logic [3:0] dest, input logic lock, input logic fs, input logic ds);
      i_op = op; i_alu = a; i_sd = d; i_dest = dest;
      i_lock = lock; i_fs = fs; i_ds = ds;
      @(posedge clk);
   endtask

   initial begin
      @(posedge clk);
      @(posedge clk);
      check("rst_ledr", 32'(o_ledr), 32'h0);
      check("rst_hex", 32'(o_hex), 32'h0);
      check("rst_regwrite", 32'(o_rw), 32'h0);
      check("rst_lock", 32'(o_lock), 32'h0);
      check("rst_memout", 32'(o_mem), 32'h0);
      rst = 1'b0;

      issue(OP_STW, 16'h0005, 16'hBEEF, 4'd0, 1'b1, 1'b0, 1'b0);
      check("stw_regwrite", 32'(o_rw), 32'h0);
      check("stw_lock", 32'(o_lock), 32'h1);
      issue(OP_LDW, 16'h0005, 16'h0000, 4'd3, 1'b1, 1'b0, 1'b0);
      check("ldw_memout", 32'(o_mem), 32'hBEEF);
      check("ldw_regwrite", 32'(o_rw), 32'h1);
      check("ldw_opcode", 32'(o_op), 32'(OP_LDW));
      check("ldw_dest", 32'(o_dest), 32'h3);

      issue(OP_STW, 16'h0405, 16'h1234, 4'd0, 1'b1, 1'b0, 1'b0);
      issue(OP_LDW, 16'h0005, 16'h0000, 4'd1, 1'b1, 1'b0, 1'b0);
      check("wrap_memout", 32'(o_mem), 32'h1234);

      issue(OP_STW, 16'hFF00, 16'hFFFF, 4'd0, 1'b1, 1'b0, 1'b0);
      check("ledr_write", 32'(o_ledr), 32'h3FF);
      issue(OP_LDW, 16'hFF00, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b0);
      check("ledr_read", 32'(o_mem), 32'h03FF);
      issue(OP_STW, 16'hFF01, 16'hCAFE, 4'd0, 1'b1, 1'b0, 1'b0);
      check("hex_write", 32'(o_hex), 32'hCAFE);
      issue(OP_LDW, 16'hFF01, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b0);
      check("hex_read", 32'(o_mem), 32'hCAFE);

      i_sw = 10'h2A5;
      for (int i = 0; i < 3; i++)
         issue(OP_NOP, 16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0);
      check("nop_regwrite", 32'(o_rw), 32'h0);
      issue(OP_LDW, 16'hFF02, 16'h0000, 4'd4, 1'b1, 1'b0, 1'b0);
      check("sw_read", 32'(o_mem), 32'h02A5);
      issue(OP_STW, 16'hFF02, 16'h1111, 4'd0, 1'b1, 1'b0, 1'b0);
      check("sw_stw_ledr", 32'(o_ledr), 32'h3FF);
      check("sw_stw_hex", 32'(o_hex), 32'hCAFE);
      issue(OP_LDW, 16'hFF02, 16'h0000, 4'd4, 1'b1, 1'b0, 1'b0);
      check("sw_read_again", 32'(o_mem), 32'h02A5);

      issue(OP_STW, 16'h0007, 16'hAAAA, 4'd0, 1'b1, 1'b0, 1'b0);
      issue(OP_STW, 16'h0007, 16'h5555, 4'd0, 1'b1, 1'b0, 1'b1);
      check("dep_regwrite", 32'(o_rw), 32'h0);
      check("dep_flag", 32'(o_ds), 32'h1);
      issue(OP_LDW, 16'h0007, 16'h0000, 4'd5, 1'b1, 1'b0, 1'b1);
      check("bubble_memout_hold", 32'(o_mem), 32'h02A5);
      check("bubble_alu_update", 32'(o_alu), 32'h0007);
      issue(OP_LDW, 16'h0007, 16'h0000, 4'd5, 1'b1, 1'b0, 1'b0);
      check("dep_ram_unchanged", 32'(o_mem), 32'hAAAA);
      check("dep_flag_clear", 32'(o_ds), 32'h0);

      issue(OP_ADD, 16'h0042, 16'h0000, 4'd6, 1'b0, 1'b0, 1'b0);
      check("nolock_regwrite", 32'(o_rw), 32'h0);
      check("nolock_lock", 32'(o_lock), 32'h0);
      check("nolock_alu", 32'(o_alu), 32'h0042);
      issue(OP_ADD, 16'h1357, 16'h0000, 4'd9, 1'b1, 1'b0, 1'b0);
      check("add_regwrite", 32'(o_rw), 32'h1);
      check("add_alu", 32'(o_alu), 32'h1357);
      check("add_dest", 32'(o_dest), 32'h9);
      issue(OP_ADD, 16'h0001, 16'h0000, 4'd9, 1'b1, 1'b1, 1'b0);
      check("fstall_regwrite", 32'(o_rw), 32'h0);
      check("fstall_flag", 32'(o_fs), 32'h1);
      issue(OP_JMP, 16'h0010, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0);
      check("jmp_regwrite", 32'(o_rw), 32'h0);
      issue(OP_BEQ, 16'h0010, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0);
      check("br_regwrite", 32'(o_rw), 32'h0);
      issue(OP_ADD, 16'h0001, 16'h0000, 4'd1, 1'b1, 1'b0, 1'b0);
      check("pre_rst_lock", 32'(o_lock), 32'h1);

      #1 rst = 1'b1;
      #1;
      check("midrst_ledr", 32'(o_ledr), 32'h0);
      check("midrst_hex", 32'(o_hex), 32'h0);
      check("midrst_regwrite", 32'(o_rw), 32'h0);
      check("midrst_lock", 32'(o_lock), 32'h0);
      @(posedge clk);
      rst = 1'b0;
      issue(OP_LDW, 16'h0005, 16'h0000, 4'd1, 1'b1, 1'b0, 1'b0);
      check("ram_survives_rst", 32'(o_mem), 32'h1234);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Fourth stage of the 5-stage pipeline. Receives the execute stage's registered outputs (ALU result, opcode, destination index, lock, stall flags) and performs the data-memory access.
- Holds the data RAM and the memory-mapped LED/HEX/switch I/O registers.
- Registers load data and pass-through results to the writeback stage.
- Updates on the falling clock edge, the same as the execute stage.

Parameters:
- DATA_WIDTH, 16, register/data word width (matches REG_WIDTH).
- OPCODE_WIDTH, 8, opcode width.
- ADDR_BITS, 10, data RAM word-address bits; depth is 2**ADDR_BITS words.
- LEDR_ADDR, 16'hFF00, word address of the LED output register.
- HEX_ADDR, 16'hFF01, word address of the 7-segment output register.
- SW_ADDR, 16'hFF02, word address of the switch input register (read-only).

Ports:
- I_CLOCK  in  1  pipeline clock; stage updates on negedge.
- I_RESET  in  1  asynchronous, active-high reset.
- I_LOCK  in  1  upstream valid/lock from the execute stage.
- I_ALUOut  in  DATA_WIDTH  ALU result; the effective address for LDW/STW.
- I_StoreData  in  DATA_WIDTH  source register value to store on STW.
- I_Opcode  in  OPCODE_WIDTH  opcode from the execute stage.
- I_DestRegIdx  in  4  destination register index.
- I_FetchStall  in  1  bubble flag from fetch.
- I_DepStall  in  1  bubble flag from the dependency check.
- I_Switches  in  10  board switches.
- O_LOCK  out  1  valid/lock to writeback.
- O_ALUOut  out  DATA_WIDTH  ALU result passed through.
- O_MemOut  out  DATA_WIDTH  load data.
- O_Opcode  out  OPCODE_WIDTH  opcode passed through.
- O_DestRegIdx  out  4  destination index passed through.
- O_RegWrite  out  1  writeback enable.
- O_FetchStall  out  1  registered copy of I_FetchStall.
- O_DepStall  out  1  registered copy of I_DepStall.
- O_LEDR  out  10  LED register.
- O_HEX  out  16  7-segment register (4 nibbles).

Behaviour:
- Reset (I_RESET high, asynchronous):
  - All outputs go to 0 immediately and stay 0 while I_RESET is high.
  - This includes O_LEDR, O_HEX, O_RegWrite and O_LOCK.
  - The switch synchronizer flops clear to 0.
  - RAM contents are not cleared.
  - A store presented on the same edge that reset asserts is discarded.
- Switch input:
  - I_Switches pass through a 2-flop synchronizer clocked on negedge.
  - SW reads return the synchronized value, zero-extended.
- Every negedge, outside reset:
  - O_LOCK <= I_LOCK.
  - O_FetchStall <= I_FetchStall.
  - O_DepStall <= I_DepStall.
- Valid instruction: valid = I_LOCK & ~I_FetchStall & ~I_DepStall.
- Bubble (valid low):
  - No RAM write and no I/O register write.
  - O_RegWrite <= 0.
  - O_Opcode, O_DestRegIdx and O_ALUOut still update; O_MemOut holds.
- Valid instruction, latency one negedge:
  - O_Opcode <= I_Opcode.
  - O_DestRegIdx <= I_DestRegIdx.
  - O_ALUOut <= I_ALUOut.
- LDW (valid), address A = I_ALUOut:
  - A == LEDR_ADDR: O_MemOut <= {0, O_LEDR}.
  - A == HEX_ADDR: O_MemOut <= O_HEX.
  - A == SW_ADDR: O_MemOut <= synchronized switches.
  - Otherwise: O_MemOut <= RAM[A[ADDR_BITS-1:0]]. Upper address bits are ignored, so addresses wrap modulo the RAM depth.
  - O_RegWrite <= 1.
- STW (valid):
  - A == LEDR_ADDR: O_LEDR <= I_StoreData[9:0].
  - A == HEX_ADDR: O_HEX <= I_StoreData.
  - A == SW_ADDR: the write is ignored.
  - Otherwise: RAM[A[ADDR_BITS-1:0]] <= I_StoreData.
  - O_RegWrite <= 0.
- Branch-class, JMP, RET, NOP (valid): O_RegWrite <= 0.
- All other valid opcodes: O_RegWrite <= 1.
- Read-after-write: an LDW on the edge after a STW to the same address returns the newly stored value. RAM write is synchronous; the read uses the array state before the current edge's write.
- Store and load cannot coincide, since one instruction is handled per edge.
- Opcode encodings come from the global definition header.

Test Plan:
- Reset: assert I_RESET mid-cycle with LEDR=0x3FF -> O_LEDR, O_HEX, O_RegWrite and O_LOCK go to 0 before the next edge.
- Store then load: STW A=0x0005 data=0xBEEF, then LDW A=0x0005 -> O_MemOut=0xBEEF and O_RegWrite=1 one edge after the LDW. O_RegWrite=0 during the STW.
- Address wrap: STW A=0x0405 data=0x1234, then LDW A=0x0005 -> O_MemOut=0x1234 (ADDR_BITS=10).
- LED and HEX I/O:
  - STW A=0xFF00 data=0xFFFF -> O_LEDR=0x3FF.
  - STW A=0xFF01 data=0xCAFE -> O_HEX=0xCAFE.
  - LDW A=0xFF01 -> O_MemOut=0xCAFE.
- Switch I/O: I_Switches=0x2A5 held for 3 edges, then LDW A=0xFF02 -> O_MemOut=0x02A5. STW to 0xFF02 leaves state unchanged.
- Bubbles:
  - STW A=0x0007 data=0x5555 with I_DepStall=1 -> RAM[7] is unchanged (a later LDW returns the old value), O_RegWrite=0, O_DepStall=1.
  - ADD with I_LOCK=0 -> O_RegWrite=0.
